// File: rtl/axi_read_slv_sram.sv
// AXI4 read-channel responder in front of a 1-cycle-latency synchronous SRAM.
// AR requests are queued in order; each burst is walked one beat at a time,
// with every beat costing one SRAM read followed by one R handshake.
module axi_read_slv_sram #(
    parameter int unsigned ARID_WIDTH   = 4,
    parameter int unsigned ARADDR_WIDTH = 10,
    parameter int unsigned RDATA_WIDTH  = 64,
    parameter int unsigned MEM_AW       = 7,
    parameter int unsigned AR_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ARID_WIDTH-1:0]   ARID,
    input  logic [ARADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [3:0]              ARREGION,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ARID_WIDTH-1:0]   RID,
    output logic [RDATA_WIDTH-1:0]  RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    mem_rd_en,
    output logic [MEM_AW-1:0]       mem_rd_addr,
    input  logic [RDATA_WIDTH-1:0]  mem_rd_data
);
    localparam int unsigned BPW      = RDATA_WIDTH / 8;
    localparam int unsigned BPW_LOG2 = $clog2(BPW);
    localparam int unsigned PTR_W    = $clog2(AR_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // Region is not decoded by this responder.
    logic unused_region;
    assign unused_region = ^ARREGION;

    // ---------------- AR queue ----------------
    logic [ARID_WIDTH-1:0]   q_id    [AR_DEPTH];
    logic [ARADDR_WIDTH-1:0] q_addr  [AR_DEPTH];
    logic [7:0]              q_len   [AR_DEPTH];
    logic [2:0]              q_size  [AR_DEPTH];
    logic [1:0]              q_burst [AR_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ar_en_q;  // holds ARREADY low through reset
    logic             full, empty, push, pop;

    assign full    = (count_q == CNT_W'(AR_DEPTH));
    assign empty   = (count_q == '0);
    assign ARREADY = ar_en_q & ~full;
    assign push    = ARVALID & ARREADY;

    // Queue pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ar_en_q  <= 1'b0;
        end else begin
            ar_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Queue storage; contents are don't-care while the entry is free.
    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr_q]    <= ARID;
            q_addr[wr_ptr_q]  <= ARADDR;
            q_len[wr_ptr_q]   <= ARLEN;
            q_size[wr_ptr_q]  <= ARSIZE;
            q_burst[wr_ptr_q] <= ARBURST;
        end
    end

    logic [ARADDR_WIDTH-1:0] head_addr;
    logic [7:0]              head_len;
    logic [2:0]              head_size;
    logic [1:0]              head_burst;
    logic                    head_err;
    logic [ARADDR_WIDTH-1:0] head_align_mask;

    assign head_addr       = q_addr[rd_ptr_q];
    assign head_len        = q_len[rd_ptr_q];
    assign head_size       = q_size[rd_ptr_q];
    assign head_burst      = q_burst[rd_ptr_q];
    assign head_align_mask = (ARADDR_WIDTH'(1) << head_size) - ARADDR_WIDTH'(1);

    // Whole-burst SLVERR decision for the request at the queue head.
    always_comb begin
        head_err = 1'b0;
        if (head_burst == 2'b11)                      head_err = 1'b1;
        if (head_size > 3'(BPW_LOG2))                 head_err = 1'b1;
        if ((head_addr & head_align_mask) != '0)      head_err = 1'b1;
        if (head_burst == 2'b10 &&
            !(head_len inside {8'd1, 8'd3, 8'd7, 8'd15})) head_err = 1'b1;
    end

    // ---------------- burst walker ----------------
    state_e                  state_q, state_d;
    logic [ARID_WIDTH-1:0]   id_q, id_d;
    logic [ARADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic [RDATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic [ARADDR_WIDTH-1:0] step, incr_addr, wrap_mask, next_addr;
    logic                    last_beat, rd_en;
    logic [MEM_AW-1:0]       rd_word;

    assign step      = ARADDR_WIDTH'(1) << size_q;
    assign incr_addr = addr_q + step;
    assign wrap_mask = ((ARADDR_WIDTH'(len_q) + ARADDR_WIDTH'(1)) << size_q) - ARADDR_WIDTH'(1);
    assign last_beat = (cnt_q == len_q);

    // Address of the following beat for the current burst type.
    always_comb begin
        unique case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    // Next-state, burst context and SRAM read strobe.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        pop     = 1'b0;
        rd_en   = 1'b0;
        rd_word = head_addr[ARADDR_WIDTH-1:BPW_LOG2];
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    id_d    = q_id[rd_ptr_q];
                    addr_d  = head_addr;
                    len_d   = head_len;
                    size_d  = head_size;
                    burst_d = head_burst;
                    err_d   = head_err;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (head_err) begin
                        state_d = StResp;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                rdata_d = mem_rd_data;
                state_d = StResp;
            end
            StResp: begin
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr;
                        if (!err_q) begin
                            rd_en   = 1'b1;
                            rd_word = next_addr[ARADDR_WIDTH-1:BPW_LOG2];
                            state_d = StWait;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst context and R-channel registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_rd_en   = rd_en & rst_n;
    assign mem_rd_addr = rd_word;
    assign RVALID      = (state_q == StResp);
    assign RLAST       = RVALID & last_beat;
    assign RRESP       = (RVALID && err_q) ? 2'b10 : 2'b00;
    assign RID         = id_q;
    assign RDATA       = rdata_q;

endmodule

// File: tb/tb_axi_read_slv_sram.sv
// Scoreboard bench for axi_read_slv_sram: directed AR requests push expected
// SRAM word reads and R beats; a monitor pops and compares as they appear.
module tb_axi_read_slv_sram;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ARID;
    logic [9:0]  ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;

    always #5 clk = ~clk;

    axi_read_slv_sram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ARID        (ARID),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARREGION    (ARREGION),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RID         (RID),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t      exp_q[$];
    logic [6:0] addr_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [63:0] memval(input logic [6:0] w);
        return {32'hC0DE_0000 | {25'd0, w}, 32'h5A5A_5A00 ^ {25'd0, w}};
    endfunction

    // SRAM model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memval(mem_rd_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_ok(input logic [3:0] id, input logic [6:0] w, input logic last);
        beat_t b;
        b.id = id; b.data = memval(w); b.resp = 2'b00; b.last = last;
        addr_q.push_back(w);
        exp_q.push_back(b);
    endtask

    task automatic exp_err(input logic [3:0] id, input logic last);
        beat_t b;
        b.id = id; b.data = 64'd0; b.resp = 2'b10; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ARREADY === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_checks++; n_errors++;
            $display("FAIL ar_handshake: id %0d got no ARREADY, required within 200 cycles", id);
        end
        ARVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && addr_q.size() == 0) begin done = 1'b1; break; end
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s drain: %0d beats / %0d reads outstanding, required 0",
                     name, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (RVALID === 1'b1) break;
        end
    endtask

    // Monitor: compare every SRAM read and every R handshake against the queues.
    initial begin
        beat_t      got, want;
        logic [6:0] wa;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (mem_rd_en === 1'b1) begin
                    n_checks++;
                    if (addr_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL mem_rd: got read of word %0d, required no read", mem_rd_addr);
                    end else begin
                        wa = addr_q.pop_front();
                        if (mem_rd_addr !== wa) begin
                            n_errors++;
                            $display("FAIL mem_rd_addr: got %0d expected %0d", mem_rd_addr, wa);
                        end
                    end
                end
                if (RVALID === 1'b1 && RREADY === 1'b1) begin
                    got.id = RID; got.data = RDATA; got.resp = RRESP; got.last = RLAST;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL r_beat: got id=%0d data=%h resp=%b last=%b, required none",
                                 got.id, got.data, got.resp, got.last);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            n_errors++;
                            $display("FAIL r_beat: got id=%0d data=%h resp=%b last=%b expected id=%0d data=%h resp=%b last=%b",
                                     got.id, got.data, got.resp, got.last,
                                     want.id, want.data, want.resp, want.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic seen;
        rst_n = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
        ARBURST = '0; ARREGION = 4'h5; RREADY = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ARREADY", 64'(ARREADY), 64'd0);
        check("rst RVALID", 64'(RVALID), 64'd0);
        check("rst RLAST", 64'(RLAST), 64'd0);
        check("rst RRESP", 64'(RRESP), 64'd0);
        check("rst RID", 64'(RID), 64'd0);
        check("rst RDATA", RDATA, 64'd0);
        check("rst mem_rd_en", 64'(mem_rd_en), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single beat, with AR-to-RVALID latency
        exp_ok(4'd3, 7'd2, 1'b1);
        send_ar(4'd3, 10'h010, 8'd0, 3'd3, 2'b01);
        wait_rvalid(n);
        check("single latency", 64'(n), 64'd3);
        drain("single");

        // INCR burst: words 8..11
        exp_ok(4'd1, 7'd8, 1'b0);  exp_ok(4'd1, 7'd9, 1'b0);
        exp_ok(4'd1, 7'd10, 1'b0); exp_ok(4'd1, 7'd11, 1'b1);
        send_ar(4'd1, 10'h040, 8'd3, 3'd3, 2'b01);
        drain("incr");

        // WRAP burst from 0x050 over a 32-byte window: words 10,11,8,9
        exp_ok(4'd2, 7'd10, 1'b0); exp_ok(4'd2, 7'd11, 1'b0);
        exp_ok(4'd2, 7'd8, 1'b0);  exp_ok(4'd2, 7'd9, 1'b1);
        send_ar(4'd2, 10'h050, 8'd3, 3'd3, 2'b10);
        drain("wrap");

        // Backpressure: first beat must hold stable with no new read
        @(posedge clk); #1 RREADY = 1'b0;
        exp_ok(4'd4, 7'd32, 1'b0); exp_ok(4'd4, 7'd33, 1'b1);
        send_ar(4'd4, 10'h100, 8'd1, 3'd3, 2'b01);
        wait_rvalid(n);
        check("bp latency", 64'(n), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp RVALID", 64'(RVALID), 64'd1);
            check("bp RDATA", RDATA, memval(7'd32));
            check("bp RID", 64'(RID), 64'd4);
            check("bp RLAST", 64'(RLAST), 64'd0);
            check("bp mem_rd_en", 64'(mem_rd_en), 64'd0);
        end
        @(posedge clk); #1 RREADY = 1'b1;
        drain("backpressure");

        // Queue full: one burst stalled in the R channel plus four queued
        @(posedge clk); #1 RREADY = 1'b0;
        for (int i = 1; i <= 6; i++) exp_ok(4'(i), 7'(39 + i), 1'b1);
        for (int i = 1; i <= 5; i++) send_ar(4'(i), 10'((39 + i) * 8), 8'd0, 3'd3, 2'b01);
        @(posedge clk); #1;
        ARID = 4'd6; ARADDR = 10'(45 * 8); ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01;
        ARVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full ARREADY", 64'(ARREADY), 64'd0);
        end
        @(posedge clk); #1 RREADY = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (ARREADY === 1'b1) begin seen = 1'b1; break; end
        end
        check("full reopen seen", 64'(seen), 64'd1);
        check("full reopen delay", 64'(n), 64'd3);
        @(posedge clk); #1 ARVALID = 1'b0;
        drain("queue_full");

        // Reserved burst type: two SLVERR beats, no SRAM reads
        exp_err(4'd7, 1'b0); exp_err(4'd7, 1'b1);
        send_ar(4'd7, 10'h080, 8'd1, 3'd3, 2'b11);
        drain("slverr");

        // Reset in the middle of an 8-beat INCR burst
        for (int i = 0; i < 8; i++) exp_ok(4'd8, 7'(64 + i), 1'(i == 7));
        send_ar(4'd8, 10'h200, 8'd7, 3'd3, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() <= 6) begin seen = 1'b1; break; end
        end
        check("midburst reached", 64'(seen), 64'd1);
        @(posedge clk); #1;
        RREADY = 1'b0; rst_n = 1'b0;
        exp_q.delete(); addr_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-rst RVALID", 64'(RVALID), 64'd0);
        check("post-rst ARREADY", 64'(ARREADY), 64'd0);
        @(posedge clk); #1 RREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post-rst no beat", 64'(RVALID), 64'd0);
        end
        check("post-rst ARREADY up", 64'(ARREADY), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
